// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and constants for the seven-segment display arbiter
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SHARE = 2'd2
    } seg7_state_e;

    localparam int          DIGITS    = 4;
    localparam logic [3:0]  SEL_BLANK = 4'b0000;

endpackage

// File: rtl/seg7_rr_pick.sv
// rtl/seg7_rr_pick.sv - combinational round-robin picker with optional excluded index
module seg7_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    // Scan from rr_ptr upward with wrap; the first eligible requester wins.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req[idx] && !(excl_en && (idx == int'(excl_idx)))) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - shares one Seg7 driver between requesters with dwell and urgent preempt
module seg7_display_arbiter
    import seg7_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int TICK_DIV    = 50000,
    parameter int DWELL_TICKS = 2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  req_num,
    input  logic [4*NUM_REQ-1:0]   req_sel,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [15:0]            num_out,
    output logic [DIGITS-1:0]      sel_out,
    output logic                   busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int DW_W  = $clog2(DWELL_TICKS + 1);

    seg7_state_e         state;
    seg7_state_e         state_nxt;
    logic [IDX_W-1:0]    owner;
    logic [IDX_W-1:0]    owner_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  pick;
    logic                found;
    logic                grant_evt;
    logic                owner_req;
    logic                tick;
    logic [PS_W-1:0]     prescaler;
    logic [DW_W-1:0]     dwell;

    // Outside IDLE the current owner is excluded so "found" means someone else wants the display.
    seg7_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .excl_en  (state != ST_IDLE),
        .excl_idx (owner),
        .pick     (pick),
        .found    (found)
    );

    // Convert the one-hot pick into an owner index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign owner_req = req[owner];
    assign tick      = (prescaler == PS_W'(TICK_DIV - 1));

    // Next-state and next-owner decisions; grant_evt marks every ownership change.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        grant_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    owner_nxt = pick_idx;
                    state_nxt = ST_HOLD;
                    grant_evt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!owner_req) begin
                    if (found) begin
                        owner_nxt = pick_idx;
                        state_nxt = ST_HOLD;
                        grant_evt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (req[0] && (owner != '0)) begin
                    owner_nxt = '0;
                    state_nxt = ST_HOLD;
                    grant_evt = 1'b1;
                end else if (tick && (dwell == DW_W'(DWELL_TICKS - 1))) begin
                    // Last tick of the dwell: sharing is allowed from the next cycle on.
                    state_nxt = ST_SHARE;
                end
            end
            ST_SHARE: begin
                if (!owner_req) begin
                    if (found) begin
                        owner_nxt = pick_idx;
                        state_nxt = ST_HOLD;
                        grant_evt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (found) begin
                    // Urgent requester jumps the rotation order when it is waiting.
                    owner_nxt = (req[0] && (owner != '0)) ? '0 : pick_idx;
                    state_nxt = ST_HOLD;
                    grant_evt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner, rotation pointer and dwell timing registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            prescaler <= '0;
            dwell     <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (grant_evt) begin
                rr_ptr    <= (owner_nxt == IDX_W'(NUM_REQ - 1)) ? '0 : owner_nxt + 1'b1;
                prescaler <= '0;
                dwell     <= '0;
            end else if (state_nxt == ST_IDLE) begin
                prescaler <= '0;
                dwell     <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick && (dwell != DW_W'(DWELL_TICKS))) begin
                    dwell <= dwell + 1'b1;
                end
            end
        end
    end

    // Registered display outputs follow the next owner's live data every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            num_out <= '0;
            sel_out <= SEL_BLANK;
            busy    <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            gnt     <= '0;
            sel_out <= SEL_BLANK;
            busy    <= 1'b0;
        end else begin
            gnt     <= NUM_REQ'(1) << owner_nxt;
            num_out <= req_num[int'(owner_nxt)*16 +: 16];
            sel_out <= req_sel[int'(owner_nxt)*4 +: 4];
            busy    <= 1'b1;
        end
    end

endmodule

// File: doc/seg7_display_arbiter.md
Name: seg7_display_arbiter

Overview:
Shares the single 4-digit seven-segment display driver (Seg7) between NUM_REQ independent requesters, such as the CPU MMIO port, the debug monitor and the fault reporter. Each requester asks for the display with a req/gnt handshake. The arbiter grants one owner at a time, holds it for a minimum dwell time, then rotates round-robin. Requester 0 is urgent and preempts any other owner. Outputs feed Seg7 num/sel directly.

Parameters:
NUM_REQ, 3, number of requesters (2..8); index 0 is urgent
TICK_DIV, 50000, clk cycles per dwell tick (>=2)
DWELL_TICKS, 2000, ticks an owner holds the display before it may be displaced (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  request for the display, one bit per requester; level, held while wanted
req_num  in  16*NUM_REQ  per-requester 16-bit hex value; requester i occupies bits [16i+15:16i]
req_sel  in  4*NUM_REQ  per-requester digit-enable mask; requester i occupies bits [4i+3:4i]
gnt  out  NUM_REQ  one-hot grant; all-zero when idle
num_out  out  16  value to Seg7 num
sel_out  out  4  digit mask to Seg7 sel; 4'b0000 blanks the display
busy  out  1  high whenever any grant is active

Behaviour:
- Reset (rst high at a clk edge): state IDLE, gnt=0, num_out=0, sel_out=0, busy=0, rr_ptr=0, prescaler=0, dwell=0. rst overrides all other events, including mid-dwell.
- Round-robin pick: first requester with req set, scanning from rr_ptr upward with wrap modulo NUM_REQ. The current owner is excluded when rotating.
- Latency: all decisions are registered. A request seen at edge t produces gnt at edge t+1. num_out/sel_out are registered from the owner's req_num/req_sel every cycle, so they track live owner data with 1 cycle latency.
- On every grant change:
  - rr_ptr <= new_owner+1, wrapping at NUM_REQ.
  - prescaler and dwell reset to 0.
- Prescaler counts 0..TICK_DIV-1; tick is asserted when it wraps. dwell increments on tick, saturating at DWELL_TICKS. HOLD therefore lasts exactly DWELL_TICKS*TICK_DIV cycles.
- States:
  - IDLE: gnt=0, sel_out=0, num_out holds its last value. If any req is set, grant the RR pick and go to HOLD.
  - HOLD: owner displayed. Transitions are evaluated in priority order:
    - (1) Owner dropped req: if others are pending, grant the RR pick and go to HOLD (no idle gap); else go to IDLE.
    - (2) req[0] set and owner!=0: preempt, grant 0 and go to HOLD.
    - (3) Dwell complete: go to SHARE.
  - SHARE: owner keeps the display until another requester appears or the owner drops. Transitions:
    - Owner dropped req: same handling as HOLD rule (1).
    - Any other req set: grant the RR pick and go to HOLD. If req[0] is among the pending requests, grant 0.
- Requester 0 as owner is never preempted. It rotates away only after dwell completes and another request is pending.
- Simultaneous owner drop and new request on the same cycle: direct handover, gnt changes in one cycle.
- A requester whose req falls while it is not granted is simply not picked; there are no pending latches.
- NUM_REQ=1 degenerates to IDLE/HOLD/SHARE with the single owner only.

Decomposition:
- seg7_pkg holds the state enum (IDLE/HOLD/SHARE), the SEL_BLANK=4'b0000 constant and the DIGITS=4 constant.
- One sub-module, seg7_rr_pick: combinational round-robin picker. Inputs: req vector, rr_ptr, exclude-index. Outputs: one-hot pick plus a found flag.

Test Plan:
All scenarios use NUM_REQ=3, TICK_DIV=4, DWELL_TICKS=2 (dwell = 8 cycles).
- Reset: rst high 3 cycles with req=3'b111 -> gnt=0, sel_out=0, num_out=0 throughout. First edge after release -> gnt=3'b001.
- Single owner: req[1]=1, req_num[1]=16'h1234, req_sel[1]=4'hF -> next edge gnt=3'b010, num_out=16'h1234, sel_out=4'hF. Changing req_num[1] to 16'hBEEF appears on num_out 1 cycle later.
- Dwell and rotation:
  - req[1] granted at t0; req[2] raised at t0+2 -> gnt stays 3'b010 until t0+8, then gnt=3'b100 at t0+9.
  - Then req[1] re-raised with req[2] held -> gnt=3'b010 only after a further 8-cycle dwell.
- Urgent preempt: owner 2 in HOLD at dwell=1, req[0] raised -> gnt=3'b001 next edge and dwell restarts. With req[2] still set, owner 0 keeps the display 8 cycles, then gnt=3'b100.
- Release handover: owner 1 drops req while req[2] is set -> gnt goes 3'b010 to 3'b100 in one edge with no all-zero cycle. Then req[2] drops with none pending -> gnt=0 and sel_out=0 next edge.
- Reset mid-dwell: rst pulsed 1 cycle at dwell=1 with req[1] held -> gnt=0 that cycle, regrant 3'b010 next edge, full 8-cycle dwell restarts.
